char_scan_mux: RTL
==================

# char_scan_mux

Upstream feeder for the ASCII-to-7-segment decoder on the Nexys A7 8-digit display. It accepts received UART bytes and keeps the last NUM_DIGITS printable characters in a scrolling buffer. It time-multiplexes those characters across the digits, presenting one ASCII code plus a matching active-low anode vector per scan slot. The decoder turns ascii_char into segments combinationally; this block owns digit selection.

## Interface
- SCAN_DIV, default 100000: clock cycles per digit slot; 1 kHz per digit at 100 MHz; legal range 2..2^20.
- NUM_DIGITS, default 8: number of digits in use; legal range 1..8.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high.
- clear  in  1  synchronous buffer clear; level-sampled every cycle.
- ascii_char  out  8  character for the currently selected digit; goes to the decoder.
- an  out  8  anode enables, active low, one-hot-low; bit k = digit k, digit 0 is rightmost.
- digit_idx  out  3  index of the currently selected digit; for debug and the bench.

## Operation
- Buffer: NUM_DIGITS × 8-bit registers, buf[0] newest/rightmost; all reset to 8'h20 (space).
- Byte handling on the cycle rx_valid=1:
  - Printable byte (8'h20..8'h7E): shift left, so buf[k] ← buf[k-1]; then buf[0] ← rx_data; the oldest byte is dropped.
  - 8'h0D (CR) or 8'h0A (LF): all entries ← 8'h20.
  - 8'h08 (BS): shift right, so buf[k-1] ← buf[k]; then buf[NUM_DIGITS-1] ← 8'h20.
  - Any other byte: ignored; the buffer is unchanged.
- clear=1: all entries ← 8'h20. If clear and rx_valid are both high in the same cycle, clear wins and the byte is discarded.
- NUM_DIGITS=1: a shift is a plain overwrite; BS writes a space.
- Scan prescaler:
  - cnt runs 0..SCAN_DIV-1.
  - At the terminal count, cnt → 0 and digit_idx increments.
  - digit_idx wraps NUM_DIGITS-1 → 0.
- Outputs:
  - ascii_char ← buf[digit_idx] and an ← ~(8'b1 << digit_idx), both registered together, so they never disagree.
  - an bits ≥ NUM_DIGITS are always 1.
- Reset values: ascii_char=8'h20, an=8'hFE, digit_idx=0, cnt=0, buffer all 8'h20.
- Reset mid-slot or mid-write: everything returns to the reset values on the next edge, and any pending byte is lost.

## Timing
- Buffer write: at the edge that samples rx_valid (edge N).
- Display latency: if the written entry is the selected digit, ascii_char shows the new value at edge N+1.
- Digit advance: digit_idx, an and ascii_char all change at the same edge, one edge after cnt = SCAN_DIV-1.
- Slot length: exactly SCAN_DIV cycles. Full frame: NUM_DIGITS × SCAN_DIV cycles.
- Throughput: back-to-back rx_valid, one byte per cycle, is accepted with no loss; the block has no backpressure.
- Events that coincide with a slot change need no special handling, because the buffer and the scan logic are independent.

## Configuration
- BLANK_GAP_EN defined:
  - an = 8'hFF for the first 16 cycles of every slot; anti-ghosting.
  - ascii_char still updates at the slot start.
  - Requires SCAN_DIV > 16.
- BLANK_GAP_EN undefined: an is asserted for the whole slot.
- Reset value of an is 8'hFE in both builds.

## Structure
- Package disp_pkg holds:
  - NUM_DIGITS_MAX=8.
  - ASCII_SPACE=8'h20, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_BS=8'h08.
  - ASCII_PRINT_LO=8'h20, ASCII_PRINT_HI=8'h7E.
  - BLANK_CYCLES=16.
- Sub-module scan_timer holds the prescaler and digit counter. Its outputs are digit_idx, a slot_start pulse and, under BLANK_GAP_EN, a blank flag.
- The buffer and the byte classifier stay in the top module.

## Test plan
Bench parameters: SCAN_DIV=4, NUM_DIGITS=8.
- Reset then run 32 cycles → an steps FE,FD,FB,…,7F,FE, one step every 4 cycles; ascii_char=8'h20 throughout.
- Send "HELLO" (48 45 4C 4C 4F) as 5 back-to-back strobes → buf[4:0] = H,E,L,L,O (buf[4]=8'h48, buf[0]=8'h4F). When an=8'hFE, ascii_char=8'h4F.
- Send 10 printable bytes '0'..'9' → buf[7..0] = '2'..'9'; '0' and '1' are dropped.
- After "HELLO", send 8'h08 → buf[0]=8'h4C, buf[3]=8'h48, buf[7]=8'h20. Then send 8'h0D → all 8'h20.
- Assert clear and rx_valid (rx_data=8'h41) together → buffer all 8'h20; 'A' is absent. Send 8'h07 → buffer unchanged.
- With BLANK_GAP_EN and SCAN_DIV=32 → an=8'hFF for cycles 0..15 of each slot, then one-hot-low for cycles 16..31.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and byte classification for the ASCII display scan path.
package disp_pkg;

  localparam int         NUM_DIGITS_MAX = 8;
  localparam int         BLANK_CYCLES   = 16;

  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    BYTE_IGNORE,
    BYTE_PRINT,
    BYTE_CLEAR,
    BYTE_BACKSPACE
  } byte_class_e;

  function automatic byte_class_e classify_byte(input logic [7:0] b);
    byte_class_e cls;
    cls = BYTE_IGNORE;
    if (b >= ASCII_PRINT_LO && b <= ASCII_PRINT_HI) begin
      cls = BYTE_PRINT;
    end else if (b == ASCII_CR || b == ASCII_LF) begin
      cls = BYTE_CLEAR;
    end else if (b == ASCII_BS) begin
      cls = BYTE_BACKSPACE;
    end
    return cls;
  endfunction

endpackage

// File: rtl/char_scan_mux_scan_timer.sv
// Slot prescaler and digit counter for char_scan_mux.
// With BLANK_GAP_EN defined, also flags the blanking window at the start of each slot.
module scan_timer
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] digit_idx_o,
  output logic [2:0] digit_nxt_o,
  output logic       slot_start_o
`ifdef BLANK_GAP_EN
  ,
  output logic       blank_o
`endif
);

  localparam int               CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [2:0]       digit_inc;
  logic             slot_start;

  // slot_start is high in the last cycle of a slot, so registered outputs
  // sampled with it take the new digit on the same edge as digit_q.
  always_comb begin
    digit_inc  = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
    cnt_d      = cnt_q + CNT_W'(1);
    digit_d    = digit_q;
    slot_start = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      digit_d    = digit_inc;
      slot_start = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= 3'd0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit_idx_o  = digit_q;
  assign digit_nxt_o  = digit_inc;
  assign slot_start_o = slot_start;

`ifdef BLANK_GAP_EN
  // Blank while the upcoming cycle count is inside the anti-ghosting gap.
  assign blank_o = (32'(cnt_d) < BLANK_CYCLES);
`endif

endmodule

// File: rtl/char_scan_mux.sv
// Scrolling UART character buffer time-multiplexed across the 7-segment digits.
// Optional BLANK_GAP_EN: anodes off for the first BLANK_CYCLES cycles of every slot.
module char_scan_mux
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clear,
  output logic [7:0] ascii_char,
  output logic [7:0] an,
  output logic [2:0] digit_idx
);

  // rx_valid is a one-cycle strobe qualifying rx_data; there is no ready,
  // every strobed byte is consumed on the edge that samples it.

  logic [7:0]  char_q [NUM_DIGITS_MAX];
  logic [7:0]  char_d [NUM_DIGITS_MAX];
  logic [7:0]  ascii_q, ascii_d;
  logic [7:0]  an_q, an_d;
  logic [2:0]  digit_cur, digit_nxt, sel;
  logic        slot_start;
  byte_class_e rx_class;
`ifdef BLANK_GAP_EN
  logic        blank;
`endif

  scan_timer #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_scan_timer (
    .clk          (clk),
    .rst          (rst),
    .digit_idx_o  (digit_cur),
    .digit_nxt_o  (digit_nxt),
    .slot_start_o (slot_start)
`ifdef BLANK_GAP_EN
    ,
    .blank_o      (blank)
`endif
  );

  // Entries at or above NUM_DIGITS are never shifted into and stay blank.
  always_comb begin
    char_d   = char_q;
    rx_class = classify_byte(rx_data);
    if (clear) begin
      for (int k = 0; k < NUM_DIGITS_MAX; k++) char_d[k] = ASCII_SPACE;
    end else if (rx_valid) begin
      case (rx_class)
        BYTE_PRINT: begin
          for (int k = 1; k < NUM_DIGITS_MAX; k++) begin
            if (k < NUM_DIGITS) char_d[k] = char_q[k-1];
          end
          char_d[0] = rx_data;
        end
        BYTE_CLEAR: begin
          for (int k = 0; k < NUM_DIGITS_MAX; k++) char_d[k] = ASCII_SPACE;
        end
        BYTE_BACKSPACE: begin
          for (int k = 0; k < NUM_DIGITS_MAX - 1; k++) begin
            if (k + 1 < NUM_DIGITS) char_d[k] = char_q[k+1];
          end
          char_d[NUM_DIGITS-1] = ASCII_SPACE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sel     = slot_start ? digit_nxt : digit_cur;
    ascii_d = char_q[sel];
    an_d    = ~(8'b1 << sel);
`ifdef BLANK_GAP_EN
    if (blank) an_d = 8'hFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS_MAX; k++) char_q[k] <= ASCII_SPACE;
      ascii_q <= ASCII_SPACE;
      an_q    <= 8'hFE;
    end else begin
      char_q  <= char_d;
      ascii_q <= ascii_d;
      an_q    <= an_d;
    end
  end

  assign ascii_char = ascii_q;
  assign an         = an_q;
  assign digit_idx  = digit_cur;

endmodule
